// File: rtl/switch_debouncer.sv
// Two-channel switch conditioner. Each channel has a synchroniser, a stability counter,
// a registered debounced level, and one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch_1_raw,
  input  logic i_switch_2_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_rise_1,
  output logic o_fall_1,
  output logic o_rise_2,
  output logic o_fall_2
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [1:0] raw;
  assign raw = {i_switch_2_raw, i_switch_1_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any cycle where the synced input matches the held level restarts the count.
    always_comb begin
      cnt_d  = '0;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != lvl_q) begin
        if (cnt_q == CNT_MAX) begin
          lvl_d  = s;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
  end

  assign o_switch_1 = g_ch[0].lvl_q;
  assign o_rise_1   = g_ch[0].rise_q;
  assign o_fall_1   = g_ch[0].fall_q;
  assign o_switch_2 = g_ch[1].lvl_q;
  assign o_rise_2   = g_ch[1].rise_q;
  assign o_fall_2   = g_ch[1].fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with a short debounce window; a sliding-window model of
// raw-sample history predicts every output.
module tb_switch_debouncer;

  localparam int LIMIT = 4;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw1 = 1'b0;
  logic sw2 = 1'b0;
  logic o_switch_1, o_switch_2, o_rise_1, o_fall_1, o_rise_2, o_fall_2;

  int total = 0;
  int bad   = 0;

  bit h1[$];
  bit h2[$];
  bit m_lvl[2];
  bit m_rise[2];
  bit m_fall[2];

  switch_debouncer #(.DEBOUNCE_LIMIT(LIMIT), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_switch_1_raw(sw1), .i_switch_2_raw(sw2),
    .o_switch_1(o_switch_1), .o_switch_2(o_switch_2),
    .o_rise_1(o_rise_1), .o_fall_1(o_fall_1),
    .o_rise_2(o_rise_2), .o_fall_2(o_fall_2)
  );

  always #5 clk = ~clk;

  wire [5:0] dut_vec = {o_switch_1, o_rise_1, o_fall_1, o_switch_2, o_rise_2, o_fall_2};

  function automatic logic [5:0] exp_vec();
    return {m_lvl[0], m_rise[0], m_fall[0], m_lvl[1], m_rise[1], m_fall[1]};
  endfunction

  task automatic model_clear();
    h1.delete();
    h2.delete();
    for (int ch = 0; ch < 2; ch++) begin
      m_lvl[ch] = 1'b0; m_rise[ch] = 1'b0; m_fall[ch] = 1'b0;
    end
  endtask

  // A level is accepted when the LIMIT most recent synced samples all differ from it;
  // the synced sample at an edge is the raw sample taken SYNC edges earlier.
  task automatic model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      int n;
      int idx;
      bit v;
      bit diff;
      n = ((ch == 0) ? h1.size() : h2.size()) - 1;
      diff = 1'b1;
      for (int j = 0; j < LIMIT; j++) begin
        idx = n - SYNC - j;
        v = (idx >= 0) ? ((ch == 0) ? h1[idx] : h2[idx]) : 1'b0;
        if (v == m_lvl[ch]) diff = 1'b0;
      end
      m_rise[ch] = diff && !m_lvl[ch];
      m_fall[ch] = diff &&  m_lvl[ch];
      if (diff) m_lvl[ch] = !m_lvl[ch];
    end
  endtask

  task automatic step(input bit a, input bit b);
    sw1 = a;
    sw2 = b;
    @(posedge clk);
    h1.push_back(a);
    h2.push_back(b);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== 6'b0) begin
      bad++; $display("FAIL reset_hold: got %b want %b", dut_vec, 6'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      total++;
      if (dut_vec !== 6'b0 || exp_vec() !== 6'b0) begin
        bad++; $display("FAIL idle[%0d]: got %b want %b", i, dut_vec, 6'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    int rises;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      rises += o_rise_1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL press[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i == 5) begin
        total++;
        if (o_rise_1 !== 1'b1 || o_switch_1 !== 1'b1) begin
          bad++; $display("FAIL press_latency: rise=%b lvl=%b want 1 1", o_rise_1, o_switch_1);
        end
      end
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL press_pulse_count: got %0d want 1", rises);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL unpress[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[6];
    int rises;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      step((i < 6) ? pat[i] : 1'b0, 1'b0);
      rises += o_rise_1;
      total++;
      if (dut_vec !== exp_vec() || o_switch_1 !== 1'b0) begin
        bad++; $display("FAIL bounce[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (rises != 0) begin
      bad++; $display("FAIL bounce_no_rise: got %0d pulses want 0", rises);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL settle[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
      total++;
      if (o_rise_1 !== (i == 5)) begin
        bad++; $display("FAIL settle_rise[%0d]: got %b want %b", i, o_rise_1, (i == 5));
      end
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    total++;
    if (o_switch_2 !== 1'b1) begin
      bad++; $display("FAIL release_setup: got %b want 1", o_switch_2);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL release[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
      total++;
      if (o_fall_2 !== (i == 5) || o_rise_2 !== 1'b0 || o_switch_2 !== (i < 5)) begin
        bad++; $display("FAIL release_edge[%0d]: fall=%b rise=%b lvl=%b", i, o_fall_2, o_rise_2, o_switch_2);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      total++;
      if (o_rise_1 !== (i == 5) || o_rise_2 !== (i == 5) || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL simul[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      total++;
      if (o_switch_2 !== 1'b1 || o_rise_2 !== 1'b0 || o_fall_2 !== 1'b0 || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL indep[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit a, b;
    a = sw1; b = sw2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = !a;
      if ($urandom_range(0, 3) == 0) b = !b;
      step(a, b);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    rises = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    total++;
    if (o_switch_2 !== 1'b1 || o_switch_1 !== 1'b0) begin
      bad++; $display("FAIL midrst_setup: got %b want sw1=0 sw2=1", dut_vec);
    end
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    total++;
    if (dut_vec !== 6'b0) begin
      bad++; $display("FAIL midrst_async: got %b want %b", dut_vec, 6'b0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      rises += o_rise_1;
      total++;
      if (dut_vec !== exp_vec() || o_rise_1 !== (i == 5)) begin
        bad++; $display("FAIL midrst_rerun[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL midrst_pulse_count: got %0d want 1", rises);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions two raw mechanical switch inputs for the LED blinker; sits directly upstream of it.
- Debounced levels drive the blinker's switch inputs; the edge pulses are available to other consumers.
- Per channel: metastability synchroniser, then a stability counter, then a registered debounced level plus one-cycle rise/fall strobes.
- Both channels are identical and independent; they share one clock and one reset.

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a new level (5 ms at 50 MHz). Legal range >= 2.
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain. Legal range >= 2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_switch_1_raw  input  1  raw switch 1, asynchronous to i_clk.
- i_switch_2_raw  input  1  raw switch 2, asynchronous to i_clk.
- o_switch_1  output  1  debounced level of switch 1; feeds the blinker's i_switch_1.
- o_switch_2  output  1  debounced level of switch 2; feeds the blinker's i_switch_2.
- o_rise_1  output  1  one-cycle pulse when o_switch_1 goes 0->1.
- o_fall_1  output  1  one-cycle pulse when o_switch_1 goes 1->0.
- o_rise_2  output  1  one-cycle pulse when o_switch_2 goes 0->1.
- o_fall_2  output  1  one-cycle pulse when o_switch_2 goes 1->0.

Behaviour:
- Reset:
  - i_rst high immediately clears all synchroniser flops, counters, o_switch_*, o_rise_* and o_fall_* to 0, regardless of i_clk.
  - Reset asserted mid-count discards the partial count.
  - After release, a switch already held high needs the full latency below before o_switch goes high, and produces an o_rise pulse when it does.
- Synchroniser:
  - The raw input shifts through SYNC_STAGES flops. The last stage is the synced value "s".
  - Nothing downstream samples a raw input directly.
- Counter:
  - Width is clog2(DEBOUNCE_LIMIT). Each channel is a two-state decision on the registered level L (0 or 1).
  - s == L: counter <= 0.
  - s != L and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - s != L and counter == DEBOUNCE_LIMIT-1: L <= s, counter <= 0, and the matching edge pulse is asserted for exactly this one cycle.
  - The counter never wraps; it is reset by the accept condition or by a match.
- Glitch rejection:
  - Any single cycle with s == L during a count restarts the count from 0.
  - The new level must therefore be stable at s for DEBOUNCE_LIMIT consecutive cycles.
- Latency:
  - A clean input transition first sampled at edge k changes o_switch at edge k+SYNC_STAGES+DEBOUNCE_LIMIT-1.
  - The pulse is registered and coincident with the level change.
- Pulses:
  - o_rise_* and o_fall_* are never high together, never high for two consecutive cycles, and are 0 in every cycle without an accept.
- Channel independence:
  - Simultaneous transitions on both channels are processed independently; both may pulse in the same cycle.
- Arithmetic:
  - Counters are unsigned.
  - The comparison against DEBOUNCE_LIMIT-1 uses the full counter width; no truncation at the maximum default.

Test Plan:
1. Reset and idle: assert i_rst for 3 cycles with both raw inputs 0, release and run 20 cycles -> all outputs 0 throughout, no pulses.
2. Clean press, DEBOUNCE_LIMIT=4, SYNC_STAGES=2: raise i_switch_1_raw before edge k and hold -> o_switch_1 rises at edge k+5 with o_rise_1=1 for exactly one cycle; channel 2 outputs stay 0.
3. Bounce rejection, DEBOUNCE_LIMIT=4: i_switch_1_raw pattern 1,1,0,1,1,0 (one cycle each), then 0 held -> o_switch_1 stays 0, no o_rise_1. Then hold 1 for 10 cycles -> single o_rise_1 5 cycles after the final stable sample.
4. Release: with o_switch_2=1, drop i_switch_2_raw to 0 and hold -> o_switch_2 falls after 5 cycles, one o_fall_2 pulse, no o_rise_2.
5. Simultaneous and independent: raise both raw inputs on the same cycle -> o_rise_1 and o_rise_2 pulse in the same cycle. Then toggle channel 1 only -> channel 2 is undisturbed.
6. Reset mid-operation: hold i_switch_1_raw=1, assert i_rst asynchronously after 3 cycles of counting -> outputs 0 immediately. After release with input still 1 -> o_switch_1 rises a full 5 cycles later with one o_rise_1.
